reward_placement_manager: RTL and testbench
===========================================

// Module: reward_placement_manager
// PURPOSE
// Downstream consumer of the random reward generator. Takes a reward request (type + grid cell), probes the
// tile map for a free cell, publishes the placed reward to the renderer, detects player pickup, and runs
// per-type effect timers. Returns set_finish to the generator to end the request early.
// PARAMETERS
// GRID_W       20  map width in cells; map address = y*GRID_W + x
// GRID_H       15  map height in cells
// MAX_TRIES    8   free-cell probes before the request is abandoned
// EFFECT_TICKS 40  effect duration in tick_4hz pulses (10 s)
// PORTS
// clk            in   1  system clock
// rst            in   1  synchronous, active-high reset
// tick_4hz       in   1  one-clk-wide 4 Hz enable pulse
// set_require    in   1  generator request, level
// reward_type    in   3  1..4 valid; 0 = none
// random_xpos    in   5  requested cell x
// random_ypos    in   5  requested cell y
// player_xpos    in   5  player cell x
// player_ypos    in   5  player cell y
// map_rd_addr    out  9  tile-map read address
// map_rd_data    in   1  1 = cell blocked; valid one clk after map_rd_addr
// set_finish     out  1  request done; level, held until set_require low
// reward_valid   out  1  reward drawn on map
// reward_x/y     out  5  placed cell
// reward_kind    out  3  placed type
// pickup_pulse   out  1  one clk on pickup
// pickup_type    out  3  type picked up; held until next pickup
// effect_active  out  4  bit k-1 high while type k effect timer nonzero
// BEHAVIOUR
// - Reset: every output 0, state IDLE, tries 0, all effect timers 0. Reset mid-request drops reward at once.
// - States: IDLE, PROBE, CHECK, PLACED, DONE.
// - IDLE: set_require=1 & type!=0 -> latch x/y/type, tries=0, PROBE. Type 0 -> DONE (no placement).
// - PROBE: drive map_rd_addr = y*GRID_W + x (9-bit, registered); -> CHECK.
// - CHECK: map_rd_data=0 -> reward_valid=1, reward_x/y/kind = latched, PLACED. Latency request->valid: 3 clk.
//   map_rd_data=1 -> x = (x==GRID_W-1) ? 0 : x+1, tries+1; tries+1==MAX_TRIES -> DONE, else PROBE.
// - PLACED: player_xpos==reward_x & player_ypos==reward_y -> pickup_pulse=1 for 1 clk, pickup_type=kind,
//   reload timer[kind]=EFFECT_TICKS, reward_valid=0, DONE.
//   set_require low (upstream stay timeout) -> reward_valid=0, IDLE, no pickup.
//   Both same clk: pickup wins; DONE then sees set_require low and exits.
// - DONE: set_finish=1; set_require low -> set_finish=0, IDLE next clk. set_finish never high outside DONE.
// - set_require low in PROBE/CHECK -> IDLE, no placement, no set_finish.
// - Effect timers (4 x 6-bit): decrement on tick_4hz when nonzero; saturate at 0; reload beats decrement
//   same clk; re-pickup of active type restarts full duration. effect_active = (timer!=0).
// - x,y never exceed GRID_W-1/GRID_H-1 after wrap; input y used unmodified.
// TESTING
// - Free cell: req type 2 at (7,4), map free -> map_rd_addr=87, reward_valid at clk+3, reward_x=7, y=4, kind=2.
// - Blocked probe: (19,3) blocked, (0,3) free -> second addr 60, reward_x=0; tries=1.
// - All blocked: 8 blocked reads -> no reward_valid, set_finish high until set_require drops, then IDLE.
// - Pickup: placed type 3 at (5,5), player moves to (5,5) -> pickup_pulse 1 clk, pickup_type=3,
//   effect_active[2]=1 for exactly 40 ticks, set_finish held until set_require low.
// - Timeout vs pickup: set_require falls same clk as player match -> pickup_pulse still fires, IDLE after.
// - Reset mid-PLACED with timer=20 -> all outputs 0 next clk, effect_active=0.

Source files
------------

// File: rtl/reward_placement_manager.sv
// Places generator reward requests on free tile-map cells, publishes them to the renderer,
// detects player pickup and runs one effect timer per reward type.
module reward_placement_manager #(
  parameter int GRID_W       = 20,
  parameter int GRID_H       = 15,
  parameter int MAX_TRIES    = 8,
  parameter int EFFECT_TICKS = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_4hz,
  input  logic       set_require,
  input  logic [2:0] reward_type,
  input  logic [4:0] random_xpos,
  input  logic [4:0] random_ypos,
  input  logic [4:0] player_xpos,
  input  logic [4:0] player_ypos,
  output logic [8:0] map_rd_addr,
  input  logic       map_rd_data,
  output logic       set_finish,
  output logic       reward_valid,
  output logic [4:0] reward_x,
  output logic [4:0] reward_y,
  output logic [2:0] reward_kind,
  output logic       pickup_pulse,
  output logic [2:0] pickup_type,
  output logic [3:0] effect_active
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  if (GRID_W * GRID_H > 512) begin : g_grid_check
    $error("grid does not fit the 9-bit map address");
  end

  typedef enum logic [2:0] {IDLE, PROBE, CHECK, PLACED, DONE} state_t;

  state_t           state;
  logic [4:0]       req_x;
  logic [4:0]       req_y;
  logic [2:0]       req_kind;
  logic [TRY_W-1:0] tries;
  logic [5:0]       timer [4];
  logic [3:0]       reload;
  logic             player_hit;
  logic             type_ok;

  function automatic logic [5:0] sat_dec(input logic [5:0] t);
    return (t == 6'd0) ? 6'd0 : t - 6'd1;
  endfunction

  assign player_hit = (player_xpos == reward_x) && (player_ypos == reward_y);
  assign type_ok    = (reward_type >= 3'd1) && (reward_type <= 3'd4);

  always_comb begin
    reload = 4'b0000;
    if (state == PLACED && player_hit) begin
      case (reward_kind)
        3'd1:    reload = 4'b0001;
        3'd2:    reload = 4'b0010;
        3'd3:    reload = 4'b0100;
        3'd4:    reload = 4'b1000;
        default: reload = 4'b0000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      req_x        <= '0;
      req_y        <= '0;
      req_kind     <= '0;
      tries        <= '0;
      map_rd_addr  <= '0;
      set_finish   <= 1'b0;
      reward_valid <= 1'b0;
      reward_x     <= '0;
      reward_y     <= '0;
      reward_kind  <= '0;
      pickup_pulse <= 1'b0;
      pickup_type  <= '0;
    end else begin
      pickup_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (set_require) begin
            if (type_ok) begin
              req_x    <= random_xpos;
              req_y    <= random_ypos;
              req_kind <= reward_type;
              tries    <= '0;
              state    <= PROBE;
            end else begin
              set_finish <= 1'b1;
              state      <= DONE;
            end
          end
        end
        PROBE: begin
          if (!set_require) begin
            state <= IDLE;
          end else begin
            map_rd_addr <= 9'(32'(req_y) * GRID_W + 32'(req_x));
            state       <= CHECK;
          end
        end
        CHECK: begin
          if (!set_require) begin
            state <= IDLE;
          end else if (!map_rd_data) begin
            reward_valid <= 1'b1;
            reward_x     <= req_x;
            reward_y     <= req_y;
            reward_kind  <= req_kind;
            state        <= PLACED;
          end else begin
            // Blocked cell: slide right along the row, wrapping to column 0
            req_x <= (req_x == 5'(GRID_W - 1)) ? 5'd0 : req_x + 5'd1;
            tries <= tries + TRY_W'(1);
            if (32'(tries) + 1 == MAX_TRIES) begin
              set_finish <= 1'b1;
              state      <= DONE;
            end else begin
              state <= PROBE;
            end
          end
        end
        PLACED: begin
          // Pickup takes priority over a simultaneous upstream timeout
          if (player_hit) begin
            pickup_pulse <= 1'b1;
            pickup_type  <= reward_kind;
            reward_valid <= 1'b0;
            set_finish   <= 1'b1;
            state        <= DONE;
          end else if (!set_require) begin
            reward_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        DONE: begin
          if (!set_require) begin
            set_finish <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        timer[k] <= 6'd0;
      end else if (reload[k]) begin
        timer[k] <= 6'(EFFECT_TICKS);
      end else if (tick_4hz) begin
        timer[k] <= sat_dec(timer[k]);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      effect_active[k] = (timer[k] != 6'd0);
    end
  end

endmodule

// File: tb/tb_reward_placement_manager.sv
// Directed bench for reward_placement_manager: placement, probing, pickup, effect timers, reset.
module tb_reward_placement_manager;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_4hz;
  logic       set_require;
  logic [2:0] reward_type;
  logic [4:0] random_xpos;
  logic [4:0] random_ypos;
  logic [4:0] player_xpos;
  logic [4:0] player_ypos;
  logic [8:0] map_rd_addr;
  logic       map_rd_data;
  logic       set_finish;
  logic       reward_valid;
  logic [4:0] reward_x;
  logic [4:0] reward_y;
  logic [2:0] reward_kind;
  logic       pickup_pulse;
  logic [2:0] pickup_type;
  logic [3:0] effect_active;

  logic blocked [512];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  assign map_rd_data = blocked[map_rd_addr];

  reward_placement_manager #(
    .GRID_W(20), .GRID_H(15), .MAX_TRIES(8), .EFFECT_TICKS(40)
  ) dut (
    .clk(clk), .rst(rst), .tick_4hz(tick_4hz), .set_require(set_require),
    .reward_type(reward_type), .random_xpos(random_xpos), .random_ypos(random_ypos),
    .player_xpos(player_xpos), .player_ypos(player_ypos), .map_rd_addr(map_rd_addr),
    .map_rd_data(map_rd_data), .set_finish(set_finish), .reward_valid(reward_valid),
    .reward_x(reward_x), .reward_y(reward_y), .reward_kind(reward_kind),
    .pickup_pulse(pickup_pulse), .pickup_type(pickup_type), .effect_active(effect_active)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    tick_4hz = 1'b1;
    step(1);
    tick_4hz = 1'b0;
    step(1);
  endtask

  task automatic request(input logic [2:0] t, input logic [4:0] x, input logic [4:0] y);
    reward_type = t;
    random_xpos = x;
    random_ypos = y;
    set_require = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 512; i++) blocked[i] = 1'b0;
    rst = 1'b1; tick_4hz = 1'b0; set_require = 1'b0; reward_type = 3'd0;
    random_xpos = 5'd0; random_ypos = 5'd0; player_xpos = 5'd31; player_ypos = 5'd31;
    step(3);
    n_checks++;
    if ({set_finish, reward_valid, pickup_pulse} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got %b want 000", {set_finish, reward_valid, pickup_pulse});
    end
    n_checks++;
    if ({map_rd_addr, reward_x, reward_y, reward_kind, pickup_type, effect_active} !== 29'd0) begin
      n_fail++; $display("FAIL reset_values addr=%0d x=%0d y=%0d kind=%0d ptype=%0d eff=%b want all 0",
                        map_rd_addr, reward_x, reward_y, reward_kind, pickup_type, effect_active);
    end
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_free_cell();
    request(3'd2, 5'd7, 5'd4);
    step(2);
    n_checks++;
    if (map_rd_addr !== 9'd87 || reward_valid !== 1'b0) begin
      n_fail++; $display("FAIL free_addr got addr=%0d valid=%b want 87/0", map_rd_addr, reward_valid);
    end
    step(1);
    n_checks++;
    if ({reward_valid, reward_x, reward_y, reward_kind} !== {1'b1, 5'd7, 5'd4, 3'd2}) begin
      n_fail++; $display("FAIL free_place got v=%b x=%0d y=%0d k=%0d want 1/7/4/2",
                        reward_valid, reward_x, reward_y, reward_kind);
    end
    set_require = 1'b0;
    step(1);
    n_checks++;
    if ({reward_valid, set_finish, pickup_pulse} !== 3'b000) begin
      n_fail++; $display("FAIL free_timeout got %b want 000", {reward_valid, set_finish, pickup_pulse});
    end
  endtask

  task automatic test_blocked_probe();
    blocked[79] = 1'b1;
    request(3'd1, 5'd19, 5'd3);
    step(2);
    n_checks++;
    if (map_rd_addr !== 9'd79) begin
      n_fail++; $display("FAIL blocked_first_addr got %0d want 79", map_rd_addr);
    end
    step(2);
    n_checks++;
    if (map_rd_addr !== 9'd60 || reward_valid !== 1'b0) begin
      n_fail++; $display("FAIL blocked_second_addr got addr=%0d valid=%b want 60/0", map_rd_addr, reward_valid);
    end
    step(1);
    n_checks++;
    if ({reward_valid, reward_x, reward_y} !== {1'b1, 5'd0, 5'd3}) begin
      n_fail++; $display("FAIL blocked_wrap got v=%b x=%0d y=%0d want 1/0/3", reward_valid, reward_x, reward_y);
    end
    set_require = 1'b0;
    blocked[79] = 1'b0;
    step(1);
  endtask

  task automatic test_all_blocked();
    int valid_seen = 0;
    for (int i = 50; i < 58; i++) blocked[i] = 1'b1;
    request(3'd4, 5'd10, 5'd2);
    for (int c = 0; c < 16; c++) begin
      step(1);
      if (reward_valid === 1'b1 || set_finish === 1'b1) valid_seen++;
    end
    n_checks++;
    if (valid_seen !== 0) begin
      n_fail++; $display("FAIL all_blocked_early got %0d cycles with valid/finish want 0", valid_seen);
    end
    step(1);
    n_checks++;
    if (set_finish !== 1'b1 || reward_valid !== 1'b0) begin
      n_fail++; $display("FAIL all_blocked_finish got fin=%b valid=%b want 1/0", set_finish, reward_valid);
    end
    step(3);
    n_checks++;
    if (set_finish !== 1'b1) begin
      n_fail++; $display("FAIL all_blocked_hold got %b want 1", set_finish);
    end
    set_require = 1'b0;
    step(1);
    n_checks++;
    if (set_finish !== 1'b0) begin
      n_fail++; $display("FAIL all_blocked_release got %b want 0", set_finish);
    end
    for (int i = 50; i < 58; i++) blocked[i] = 1'b0;
  endtask

  task automatic test_type_none();
    request(3'd0, 5'd1, 5'd1);
    step(1);
    n_checks++;
    if (set_finish !== 1'b1 || reward_valid !== 1'b0) begin
      n_fail++; $display("FAIL type0_finish got fin=%b valid=%b want 1/0", set_finish, reward_valid);
    end
    set_require = 1'b0;
    step(1);
    n_checks++;
    if (set_finish !== 1'b0) begin
      n_fail++; $display("FAIL type0_release got %b want 0", set_finish);
    end
  endtask

  task automatic test_abort_probe();
    request(3'd2, 5'd3, 5'd3);
    step(2);
    set_require = 1'b0;
    step(2);
    n_checks++;
    if ({reward_valid, set_finish} !== 2'b00) begin
      n_fail++; $display("FAIL abort_probe got %b want 00", {reward_valid, set_finish});
    end
  endtask

  task automatic test_pickup();
    request(3'd3, 5'd5, 5'd5);
    step(3);
    n_checks++;
    if (reward_valid !== 1'b1 || reward_kind !== 3'd3) begin
      n_fail++; $display("FAIL pickup_place got v=%b k=%0d want 1/3", reward_valid, reward_kind);
    end
    player_xpos = 5'd5; player_ypos = 5'd5;
    step(1);
    n_checks++;
    if ({pickup_pulse, pickup_type, reward_valid, set_finish, effect_active} !== {1'b1, 3'd3, 1'b0, 1'b1, 4'b0100}) begin
      n_fail++; $display("FAIL pickup_event got p=%b t=%0d v=%b fin=%b eff=%b want 1/3/0/1/0100",
                        pickup_pulse, pickup_type, reward_valid, set_finish, effect_active);
    end
    player_xpos = 5'd31; player_ypos = 5'd31;
    step(1);
    n_checks++;
    if (pickup_pulse !== 1'b0 || pickup_type !== 3'd3) begin
      n_fail++; $display("FAIL pickup_one_clk got p=%b t=%0d want 0/3", pickup_pulse, pickup_type);
    end
    for (int i = 0; i < 39; i++) tick();
    n_checks++;
    if (effect_active !== 4'b0100 || set_finish !== 1'b1) begin
      n_fail++; $display("FAIL pickup_39_ticks got eff=%b fin=%b want 0100/1", effect_active, set_finish);
    end
    tick();
    n_checks++;
    if (effect_active !== 4'b0000) begin
      n_fail++; $display("FAIL pickup_40_ticks got %b want 0000", effect_active);
    end
    set_require = 1'b0;
    step(1);
    n_checks++;
    if (set_finish !== 1'b0) begin
      n_fail++; $display("FAIL pickup_release got %b want 0", set_finish);
    end
  endtask

  task automatic test_timeout_vs_pickup();
    request(3'd1, 5'd2, 5'd2);
    step(3);
    set_require = 1'b0;
    player_xpos = 5'd2; player_ypos = 5'd2;
    step(1);
    n_checks++;
    if ({pickup_pulse, pickup_type, set_finish, effect_active} !== {1'b1, 3'd1, 1'b1, 4'b0001}) begin
      n_fail++; $display("FAIL race_pickup got p=%b t=%0d fin=%b eff=%b want 1/1/1/0001",
                        pickup_pulse, pickup_type, set_finish, effect_active);
    end
    player_xpos = 5'd31; player_ypos = 5'd31;
    step(1);
    n_checks++;
    if ({pickup_pulse, set_finish, reward_valid} !== 3'b000) begin
      n_fail++; $display("FAIL race_exit got %b want 000", {pickup_pulse, set_finish, reward_valid});
    end
  endtask

  task automatic test_reset_mid_placed();
    for (int i = 0; i < 20; i++) tick();
    n_checks++;
    if (effect_active !== 4'b0001) begin
      n_fail++; $display("FAIL timer_20_left got %b want 0001", effect_active);
    end
    request(3'd4, 5'd9, 5'd9);
    step(3);
    n_checks++;
    if (reward_valid !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre_place got %b want 1", reward_valid);
    end
    rst = 1'b1;
    step(1);
    n_checks++;
    if ({reward_valid, set_finish, pickup_pulse, effect_active, pickup_type, reward_kind, map_rd_addr} !== 25'd0) begin
      n_fail++; $display("FAIL reset_mid_placed got v=%b fin=%b p=%b eff=%b pt=%0d k=%0d addr=%0d want all 0",
                        reward_valid, set_finish, pickup_pulse, effect_active, pickup_type, reward_kind, map_rd_addr);
    end
    rst = 1'b0;
    set_require = 1'b0;
    step(1);
  endtask

  initial begin
    test_reset();
    test_free_cell();
    test_blocked_probe();
    test_all_blocked();
    test_type_none();
    test_abort_probe();
    test_pickup();
    test_timeout_vs_pickup();
    test_reset_mid_placed();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
